// File: rtl/mat_elementwise.sv
// Element-wise float32 matrix engine: SCALE, HADAMARD, ADD, SUB over M x N,
// time-multiplexed across N_UNITS lanes of multiplier/adder handshake cores.
// Ports: clk, rst (sync, active-high); input_op/input_scalar/input_a/input_b
// with input_stb/input_ack; output_mat with output_mat_stb/output_mat_ack;
// busy high from accept until the result is taken.
// Option: define MAT_ELEMWISE_RELU_EN to zero every result with bit 31 set.

module multiplier (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    input  logic [31:0] input_b,
    input  logic        input_b_stb,
    output logic        input_b_ack,
    output logic [31:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);
    logic [31:0] a_q, b_q;
    logic        ga_q, gb_q;

    // Round-to-nearest-even; subnormals flush to zero.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic        s, g, st;
        logic [47:0] p;
        logic [23:0] m;
        logic [24:0] mr;
        logic [31:0] r;
        int          e;
        s = a[31] ^ b[31];
        r = {s, 31'b0};
        if ((&a[30:23] && |a[22:0]) || (&b[30:23] && |b[22:0])) begin
            r = 32'h7FC00000;
        end else if (&a[30:23] || &b[30:23]) begin
            if (a[30:23] == 8'd0 || b[30:23] == 8'd0) r = 32'h7FC00000;
            else r = {s, 8'hFF, 23'b0};
        end else if (a[30:23] != 8'd0 && b[30:23] != 8'd0) begin
            p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
            e = int'(a[30:23]) + int'(b[30:23]) - 127;
            if (p[47]) begin
                m  = p[47:24];
                g  = p[23];
                st = |p[22:0];
                e  = e + 1;
            end else begin
                m  = p[46:23];
                g  = p[22];
                st = |p[21:0];
            end
            mr = {1'b0, m} + 25'(g && (st || m[0]));
            if (mr[24]) e = e + 1;
            if (e >= 255) r = {s, 8'hFF, 23'b0};
            else if (e <= 0) r = {s, 31'b0};
            else r = {s, e[7:0], mr[22:0]};
        end
        return r;
    endfunction

    assign input_a_ack = ~ga_q & ~output_z_stb;
    assign input_b_ack = ~gb_q & ~output_z_stb;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q          <= '0;
            b_q          <= '0;
            ga_q         <= 1'b0;
            gb_q         <= 1'b0;
            output_z     <= '0;
            output_z_stb <= 1'b0;
        end else begin
            if (input_a_stb && input_a_ack) begin
                a_q  <= input_a;
                ga_q <= 1'b1;
            end
            if (input_b_stb && input_b_ack) begin
                b_q  <= input_b;
                gb_q <= 1'b1;
            end
            if (ga_q && gb_q) begin
                output_z     <= fmul(a_q, b_q);
                output_z_stb <= 1'b1;
                ga_q         <= 1'b0;
                gb_q         <= 1'b0;
            end
            if (output_z_stb && output_z_ack) output_z_stb <= 1'b0;
        end
    end
endmodule

module adder (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    input  logic [31:0] input_b,
    input  logic        input_b_stb,
    output logic        input_b_ack,
    output logic [31:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);
    logic [31:0] a_q, b_q;
    logic        ga_q, gb_q;

    // 26 guard bits below the mantissa; bits shifted past them fold into a
    // sticky lsb so rounding stays exact for both add and subtract.
    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x, y, r;
        logic [50:0] mx, my, sh, sum, nrm;
        logic [24:0] m;
        logic        st;
        int          d, p, e;
        r = 32'h0;
        if (&a[30:23] || &b[30:23]) begin
            if ((&a[30:23] && |a[22:0]) || (&b[30:23] && |b[22:0])) r = 32'h7FC00000;
            else if (&a[30:23] && &b[30:23] && a[31] != b[31]) r = 32'h7FC00000;
            else r = &a[30:23] ? a : b;
        end else if (a[30:23] == 8'd0 && b[30:23] == 8'd0) begin
            r = {a[31] & b[31], 31'b0};
        end else if (a[30:23] == 8'd0) begin
            r = b;
        end else if (b[30:23] == 8'd0) begin
            r = a;
        end else begin
            if (a[30:0] < b[30:0]) begin
                x = b;
                y = a;
            end else begin
                x = a;
                y = b;
            end
            d  = int'(x[30:23]) - int'(y[30:23]);
            mx = {2'b01, x[22:0], 26'b0};
            my = {2'b01, y[22:0], 26'b0};
            sh = (d > 50) ? 51'b0 : (my >> d);
            st = (d > 50) ? 1'b1 : ((sh << d) != my);
            sh[0] = sh[0] | st;
            sum = (x[31] == y[31]) ? mx + sh : mx - sh;
            if (sum != 51'b0) begin
                p = 0;
                for (int i = 0; i < 51; i++) if (sum[i]) p = i;
                nrm = sum << (50 - p);
                e   = int'(x[30:23]) + p - 49;
                m   = {1'b0, nrm[50:27]};
                if (nrm[26] && (|nrm[25:0] || m[0])) m = m + 25'd1;
                if (m[24]) e = e + 1;
                if (e >= 255) r = {x[31], 8'hFF, 23'b0};
                else if (e <= 0) r = {x[31], 31'b0};
                else r = {x[31], e[7:0], m[22:0]};
            end
        end
        return r;
    endfunction

    assign input_a_ack = ~ga_q & ~output_z_stb;
    assign input_b_ack = ~gb_q & ~output_z_stb;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q          <= '0;
            b_q          <= '0;
            ga_q         <= 1'b0;
            gb_q         <= 1'b0;
            output_z     <= '0;
            output_z_stb <= 1'b0;
        end else begin
            if (input_a_stb && input_a_ack) begin
                a_q  <= input_a;
                ga_q <= 1'b1;
            end
            if (input_b_stb && input_b_ack) begin
                b_q  <= input_b;
                gb_q <= 1'b1;
            end
            if (ga_q && gb_q) begin
                output_z     <= fadd(a_q, b_q);
                output_z_stb <= 1'b1;
                ga_q         <= 1'b0;
                gb_q         <= 1'b0;
            end
            if (output_z_stb && output_z_ack) output_z_stb <= 1'b0;
        end
    end
endmodule

module mat_elementwise #(
    parameter int M       = 2,
    parameter int N       = 2,
    parameter int N_UNITS = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                input_op,
    input  logic [31:0]               input_scalar,
    input  logic [M-1:0][N-1:0][31:0] input_a,
    input  logic [M-1:0][N-1:0][31:0] input_b,
    input  logic                      input_stb,
    output logic                      input_ack,
    output logic [M-1:0][N-1:0][31:0] output_mat,
    output logic                      output_mat_stb,
    input  logic                      output_mat_ack,
    output logic                      busy
);
    localparam int NE  = M * N;
    localparam int NB  = (NE + N_UNITS - 1) / N_UNITS;
    localparam int TOT = NB * N_UNITS;
    localparam int TW  = TOT * 32;
    localparam int BW  = (NB > 1) ? $clog2(NB) : 1;
    localparam int IW  = (TOT > 1) ? $clog2(TOT) : 1;

    typedef enum logic [1:0] {GET, ISSUE, COLLECT, PUT} state_t;

    state_t                   state_q;
    logic [1:0]               op_q;
    logic [31:0]              s_q;
    logic [TOT-1:0][31:0]     a_q, b_q, res_q;
    logic [BW-1:0]            batch_q;
    logic                     ack_q, stb_q, busy_q;
    logic [N_UNITS-1:0]       a_stb_q, b_stb_q, z_ack_q;
    logic [N_UNITS-1:0]       a_ack_w, b_ack_w, z_stb_w;
    logic [N_UNITS-1:0][31:0] z_w;
    logic [N_UNITS-1:0][IW-1:0] idx_w;
    logic                     use_mul;

    assign use_mul        = ~op_q[1];
    assign input_ack      = ack_q;
    assign output_mat_stb = stb_q;
    assign busy           = busy_q;

    for (genvar i = 0; i < N_UNITS; i++) begin : g_lane
        logic [31:0] opa, opb, bi, mz, az, zs;
        logic        ma_ack, mb_ack, mz_stb, aa_ack, ab_ack, az_stb;

        assign idx_w[i] = IW'(int'(batch_q) * N_UNITS + i);
        assign opa = a_q[idx_w[i]];
        assign bi  = b_q[idx_w[i]];
        assign opb = (op_q == 2'd0) ? s_q :
                     (op_q == 2'd3) ? {~bi[31], bi[30:0]} : bi;

        multiplier u_mul (
            .clk(clk), .rst(rst),
            .input_a(opa), .input_a_stb(a_stb_q[i] & use_mul), .input_a_ack(ma_ack),
            .input_b(opb), .input_b_stb(b_stb_q[i] & use_mul), .input_b_ack(mb_ack),
            .output_z(mz), .output_z_stb(mz_stb), .output_z_ack(z_ack_q[i] & use_mul)
        );

        adder u_add (
            .clk(clk), .rst(rst),
            .input_a(opa), .input_a_stb(a_stb_q[i] & ~use_mul), .input_a_ack(aa_ack),
            .input_b(opb), .input_b_stb(b_stb_q[i] & ~use_mul), .input_b_ack(ab_ack),
            .output_z(az), .output_z_stb(az_stb), .output_z_ack(z_ack_q[i] & ~use_mul)
        );

        assign a_ack_w[i] = use_mul ? ma_ack : aa_ack;
        assign b_ack_w[i] = use_mul ? mb_ack : ab_ack;
        assign z_stb_w[i] = use_mul ? mz_stb : az_stb;
        assign zs         = use_mul ? mz : az;
`ifdef MAT_ELEMWISE_RELU_EN
        assign z_w[i] = zs[31] ? 32'h0 : zs;
`else
        assign z_w[i] = zs;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= GET;
            op_q       <= '0;
            s_q        <= '0;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            batch_q    <= '0;
            ack_q      <= 1'b0;
            stb_q      <= 1'b0;
            busy_q     <= 1'b0;
            a_stb_q    <= '0;
            b_stb_q    <= '0;
            z_ack_q    <= '0;
            output_mat <= '0;
        end else begin
            unique case (state_q)
                GET: begin
                    ack_q <= 1'b1;
                    if (input_stb && ack_q) begin
                        ack_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        op_q    <= input_op;
                        s_q     <= input_scalar;
                        a_q     <= TW'(input_a);
                        b_q     <= TW'(input_b);
                        batch_q <= '0;
                        a_stb_q <= '1;
                        b_stb_q <= '1;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    a_stb_q <= a_stb_q & ~a_ack_w;
                    b_stb_q <= b_stb_q & ~b_ack_w;
                    if (a_stb_q == '0 && b_stb_q == '0) begin
                        z_ack_q <= '1;
                        state_q <= COLLECT;
                    end
                end
                COLLECT: begin
                    for (int i = 0; i < N_UNITS; i++) begin
                        if (z_ack_q[i] && z_stb_w[i]) begin
                            res_q[idx_w[i]] <= z_w[i];
                            z_ack_q[i]      <= 1'b0;
                        end
                    end
                    if (z_ack_q == '0) begin
                        if (batch_q == BW'(NB - 1)) begin
                            output_mat <= res_q[NE-1:0];
                            stb_q      <= 1'b1;
                            state_q    <= PUT;
                        end else begin
                            batch_q <= batch_q + BW'(1);
                            a_stb_q <= '1;
                            b_stb_q <= '1;
                            state_q <= ISSUE;
                        end
                    end
                end
                PUT: begin
                    if (output_mat_ack) begin
                        stb_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= GET;
                    end
                end
                default: state_q <= GET;
            endcase
        end
    end
endmodule
